// File: rtl/fp_to_int_pkg.sv
// Shared constants, special-case class encoding and the operand classifier
// for the float-to-integer converter.
package fp_to_int_pkg;

    localparam int WIDTH     = 32;
    localparam int EXP_BITS  = 8;
    localparam int MANT_BITS = 23;
    localparam int INT_WIDTH = 32;
    localparam int SIG_BITS  = MANT_BITS + 1;

    localparam logic signed [8:0]       BIAS    = 9'sd127;
    localparam logic [INT_WIDTH-1:0]    INT_MAX = 32'h7FFF_FFFF;
    localparam logic [INT_WIDTH-1:0]    INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_SUBN,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    function automatic fp_class_e classify(input logic [EXP_BITS-1:0]  exp_f,
                                           input logic [MANT_BITS-1:0] frac_f);
        fp_class_e cls;
        if (exp_f == '0)
            cls = (frac_f == '0) ? CLS_ZERO : CLS_SUBN;
        else if (exp_f == '1)
            cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
        else
            cls = CLS_NORM;
        return cls;
    endfunction

endpackage

// File: rtl/fp_to_int_if.sv
// Valid/ready bundle between the float producer and the converter.
// A word moves on a rising edge where valid and ready are both high; valid holds until then.
interface fp_to_int_if;
    import fp_to_int_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic                 rne;
    logic                 out_valid;
    logic                 out_ready;
    logic [INT_WIDTH-1:0] result;
    logic                 invalid;
    logic                 overflow;
    logic                 inexact;

    modport master (
        output in_valid, a, rne, out_ready,
        input  in_ready, out_valid, result, invalid, overflow, inexact
    );

    modport slave (
        input  in_valid, a, rne, out_ready,
        output in_ready, out_valid, result, invalid, overflow, inexact
    );

endinterface

// File: rtl/fp_to_int_shift.sv
// Aligns the 24-bit significand to the integer binary point, producing the
// truncated magnitude plus the guard and sticky bits used for rounding.
module fp_to_int_shift
    import fp_to_int_pkg::*;
(
    input  logic signed [8:0]          e_i,
    input  logic [SIG_BITS-1:0]        sig_i,
    output logic [INT_WIDTH-1:0]       mag_o,
    output logic                       guard_o,
    output logic                       sticky_o
);

    logic [2*SIG_BITS-1:0] wide;
    logic [4:0]            rsh;
    logic [3:0]            lsh;

    always_comb begin
        mag_o    = '0;
        guard_o  = 1'b0;
        sticky_o = 1'b0;
        wide     = '0;
        rsh      = '0;
        lsh      = '0;
        if (e_i >= 9'sd23) begin
            // Out-of-range exponents are saturated downstream; clamp only keeps the shift bounded.
            lsh   = (e_i > 9'sd31) ? 4'd8 : 4'(e_i - 9'sd23);
            mag_o = {8'b0, sig_i} << lsh;
        end else if (e_i >= -9'sd1) begin
            // e = -1 shifts by 24, which leaves the hidden one in the guard slot.
            rsh      = 5'(9'sd23 - e_i);
            wide     = {sig_i, 24'b0} >> rsh;
            mag_o    = {8'b0, wide[47:24]};
            guard_o  = wide[23];
            sticky_o = |wide[22:0];
        end else begin
            sticky_o = 1'b1;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// Three-stage float to signed integer converter: unpack/classify, align,
// then round, negate or saturate. One global stall freezes every stage.
module fp_to_int
    import fp_to_int_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    fp_to_int_if.slave  io
);

    logic advance;

    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_sign_q,  s1_sign_d;
    fp_class_e               s1_cls_q,   s1_cls_d;
    logic signed [8:0]       s1_e_q,     s1_e_d;
    logic [SIG_BITS-1:0]     s1_sig_q,   s1_sig_d;
    logic                    s1_rne_q,   s1_rne_d;

    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_sign_q,  s2_sign_d;
    fp_class_e               s2_cls_q,   s2_cls_d;
    logic                    s2_rng_q,   s2_rng_d;
    logic [INT_WIDTH-1:0]    s2_mag_q,   s2_mag_d;
    logic                    s2_guard_q, s2_guard_d;
    logic                    s2_sticky_q, s2_sticky_d;
    logic                    s2_rne_q,   s2_rne_d;

    logic                    out_valid_q, out_valid_d;
    logic [INT_WIDTH-1:0]    result_q,   result_d;
    logic                    invalid_q,  invalid_d;
    logic                    overflow_q, overflow_d;
    logic                    inexact_q,  inexact_d;

    logic                    inc;
    logic [INT_WIDTH-1:0]    mag_rnd;

    assign advance     = ~out_valid_q | io.out_ready;
    assign io.in_ready = advance;

    always_comb begin
        s1_valid_d = io.in_valid;
        s1_sign_d  = io.a[31];
        s1_cls_d   = classify(io.a[30:23], io.a[22:0]);
        s1_e_d     = $signed({1'b0, io.a[30:23]}) - BIAS;
        s1_sig_d   = {1'b1, io.a[22:0]};
        s1_rne_d   = io.rne;
    end

    fp_to_int_shift u_shift (
        .e_i      (s1_e_q),
        .sig_i    (s1_sig_q),
        .mag_o    (s2_mag_d),
        .guard_o  (s2_guard_d),
        .sticky_o (s2_sticky_d)
    );

    // -2^31 exactly is the one e = 31 value that still fits.
    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_cls_d   = s1_cls_q;
        s2_rne_d   = s1_rne_q;
        s2_rng_d   = (s1_e_q > 9'sd31) ||
                     ((s1_e_q == 9'sd31) && (!s1_sign_q || (s1_sig_q[22:0] != '0)));
    end

    assign inc     = s2_rne_q & s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
    assign mag_rnd = s2_mag_q + {{(INT_WIDTH-1){1'b0}}, inc};

    always_comb begin
        out_valid_d = s2_valid_q;
        result_d    = '0;
        invalid_d   = 1'b0;
        overflow_d  = 1'b0;
        inexact_d   = 1'b0;
        case (s2_cls_q)
            CLS_NAN: begin
                result_d  = INT_MAX;
                invalid_d = 1'b1;
            end
            CLS_INF: begin
                result_d   = s2_sign_q ? INT_MIN : INT_MAX;
                overflow_d = 1'b1;
            end
            CLS_ZERO: result_d = '0;
            CLS_SUBN: inexact_d = 1'b1;
            default: begin
                if (s2_rng_q) begin
                    result_d   = s2_sign_q ? INT_MIN : INT_MAX;
                    overflow_d = 1'b1;
                end else begin
                    result_d  = s2_sign_q ? (~mag_rnd + 32'd1) : mag_rnd;
                    inexact_d = s2_guard_q | s2_sticky_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_cls_q    <= CLS_ZERO;
            s1_e_q      <= '0;
            s1_sig_q    <= '0;
            s1_rne_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_cls_q    <= CLS_ZERO;
            s2_rng_q    <= 1'b0;
            s2_mag_q    <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_rne_q    <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            invalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            inexact_q   <= 1'b0;
        end else if (advance) begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_cls_q    <= s1_cls_d;
            s1_e_q      <= s1_e_d;
            s1_sig_q    <= s1_sig_d;
            s1_rne_q    <= s1_rne_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_cls_q    <= s2_cls_d;
            s2_rng_q    <= s2_rng_d;
            s2_mag_q    <= s2_mag_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            s2_rne_q    <= s2_rne_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            invalid_q   <= invalid_d;
            overflow_q  <= overflow_d;
            inexact_q   <= inexact_d;
        end
    end

    assign io.out_valid = out_valid_q;
    assign io.result    = result_q;
    assign io.invalid   = invalid_q;
    assign io.overflow  = overflow_q;
    assign io.inexact   = inexact_q;

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Pipelined IEEE-754 single-precision to signed integer converter. It consumes packed floats as produced by the add/sub datapath and returns a two's-complement integer with exception flags. Rounding is either truncate-toward-zero or round-to-nearest-even. It sits on the FPU result side as the decode counterpart to the float-packing path, behind a valid/ready handshake with full backpressure.

## Interface
- WIDTH, 32, float word width
- EXP_BITS, 8, exponent field width
- MANT_BITS, 23, fraction field width
- INT_WIDTH, 32, integer result width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  input word present
- in_ready  out  1  converter accepts input this cycle
- a  in  WIDTH  packed float operand
- rne  in  1  1 = round-nearest-even, 0 = truncate toward zero; sampled with `a`
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- result  out  INT_WIDTH  signed integer
- invalid  out  1  operand was NaN
- overflow  out  1  operand was ±Inf or out of range; result saturated
- inexact  out  1  a nonzero fraction was discarded (only when invalid=0 and overflow=0)

## Operation
- Fields: sign = a[31], exp = a[30:23], frac = a[22:0]. Unbiased e = exp − 127, using a signed 9-bit value. Significand sig = {1, frac} (24 bits).
- NaN (exp = 255, frac ≠ 0): result = 0x7FFF_FFFF, invalid = 1.
- +Inf, or a positive finite value with e ≥ 31: result = 0x7FFF_FFFF, overflow = 1.
- −Inf, or a negative finite value with e > 31, or with e = 31 and frac ≠ 0: result = 0x8000_0000, overflow = 1.
- e = 31, sign = 1, frac = 0: result = 0x8000_0000, no flags.
- Zero (exp = 0, frac = 0): result = 0, no flags.
- Subnormal (exp = 0, frac ≠ 0): result = 0, inexact = 1.
- 23 ≤ e ≤ 30: magnitude = sig << (e − 23). Exact, so no inexact.
- 0 ≤ e ≤ 22:
  - magnitude = sig >> (23 − e)
  - guard = sig[22 − e]
  - sticky = OR of sig bits below guard
- e < 0: magnitude = 0.
  - e = −1: guard = 1, sticky = |frac.
  - e < −1: guard = 0, sticky = 1.
- RNE increment = guard & (sticky | magnitude[0]); truncate increment = 0. Rounding cannot overflow because e ≤ 22 bounds the magnitude below 2^23.
- inexact = guard | sticky. result = sign ? −(magnitude + inc) : (magnitude + inc).
- A negative value that rounds to zero yields 0, not −0.

## Timing
- Three register stages:
  - S1 registers the unpacked fields and special-case class.
  - S2 registers the shifted magnitude, guard and sticky.
  - S3 registers the rounded, negated or saturated result and its flags.
- Latency is 3 cycles from accept to out_valid with no stall.
- Global stall: advance = ~out_valid | out_ready. in_ready = advance (combinational).
- Input is accepted when in_valid & in_ready. Each stage's valid bit is a copy of the previous stage's on advance.
- Throughput is 1 per cycle. Bubbles propagate; an empty stage never blocks.
- While out_valid & ~out_ready, result and flags hold stable and all stages freeze.
- Reset values: all stage valid bits = 0, out_valid = 0, result = 0, all flags = 0.
- in_ready = 1 in the cycle after rst deasserts.
- Reset mid-operation discards all in-flight words. No output is produced for them.
- in_valid is ignored while rst = 1.

## Structure
- Shared package:
  - bias constant 127
  - special-case class encoding: ZERO, SUBN, NORM, INF, NAN
  - INT_MAX = 0x7FFF_FFFF and INT_MIN = 0x8000_0000
- One sub-module, fp_to_int_shift: combinational 24-bit right/left shifter producing magnitude, guard and sticky. Instantiated between S1 and S2.
- Stage registers live in the top module with the reset and stall conditions above.

## Test plan
- a = 0x4049_0FDB (≈3.14159), rne = 1 → result = 3, inexact = 1. Same a with rne = 0 → 3.
- Ties:
  - a = 0x3FC0_0000 (1.5), rne = 1 → 2.
  - a = 0x4020_0000 (2.5), rne = 1 → 2.
  - a = 0xC020_0000 (−2.5), rne = 0 → 0xFFFF_FFFE.
  - All three set inexact = 1.
- Range limits:
  - a = 0xCF00_0000 (−2^31) → 0x8000_0000, no flags.
  - a = 0x4F00_0000 (2^31) → 0x7FFF_FFFF, overflow = 1.
  - a = 0xFF80_0000 (−Inf) → 0x8000_0000, overflow = 1.
- Specials:
  - a = 0x7FC0_0000 (NaN) → 0x7FFF_FFFF, invalid = 1.
  - a = 0x0000_0001 (subnormal) → 0, inexact = 1.
  - a = 0xBF00_0000 (−0.5), rne = 1 → 0, inexact = 1.
- Backpressure: send 5 back-to-back words (1.0, 2.0, 3.0, 4.0, 5.0) with out_ready low for cycles 4–6 → in_ready low during the stall; outputs 1, 2, 3, 4, 5 in order with none lost or duplicated; result stable throughout the stall.
- Reset: assert rst for 1 cycle with 3 words in flight → out_valid = 0 the next cycle and none of those words ever appear; in_ready = 1 the cycle after rst falls.
